// File: rtl/refresh_pkg.sv
// Shared refresh definitions: FSM state encoding, default timing constants and
// the backlog counter width helper, used by the refresh timer and executor.
package refresh_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StPre,
    StRef,
    StDone
  } ref_state_e;

  localparam int unsigned DefMaxPending  = 8;
  localparam int unsigned DefUrgentLevel = 6;
  localparam int unsigned DefTRp         = 3;
  localparam int unsigned DefTRfc        = 16;

  function automatic int unsigned pending_width(input int unsigned max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/ref_pending_ctr.sv
// Saturating up/down refresh backlog counter with a sticky overflow flag that
// records a request lost while the backlog was full.
module ref_pending_ctr
  import refresh_pkg::*;
#(
  parameter int unsigned MAX_PENDING = DefMaxPending,
  localparam int unsigned Width      = pending_width(MAX_PENDING)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic             overflow_o
);

  logic [Width-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    // Simultaneous increment and decrement cancel out.
    if (inc_i && !dec_i) begin
      if (count_q == Width'(MAX_PENDING)) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + Width'(1);
      end
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/refresh_executor.sv
// Refresh executor: arbitrates for the command bus per pending refresh and issues
// a precharge-all / auto-refresh pair with tRP and tRFC spacing.
module refresh_executor
  import refresh_pkg::*;
#(
  parameter int unsigned MAX_PENDING  = DefMaxPending,
  parameter int unsigned URGENT_LEVEL = DefUrgentLevel,
  parameter int unsigned T_RP         = DefTRp,
  parameter int unsigned T_RFC        = DefTRfc,
  localparam int unsigned PendW       = pending_width(MAX_PENDING)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             refresh_i,
  input  logic             ref_gnt_i,
  output logic             ref_req_o,
  output logic             ref_urgent_o,
  output logic             cmd_pre_all_o,
  output logic             cmd_ref_o,
  output logic             ref_active_o,
  output logic             ref_done_o,
  output logic [PendW-1:0] pending_o,
  output logic             overflow_o
);

  localparam int unsigned TimerMax = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int unsigned TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;

  ref_state_e        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [PendW-1:0]  pending;

  ref_pending_ctr #(
    .MAX_PENDING(MAX_PENDING)
  ) u_pending_ctr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc_i     (refresh_i),
    .dec_i     (cmd_ref_o),
    .count_o   (pending),
    .overflow_o(overflow_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // One down-counter times both phases; it is reloaded on each phase entry.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: if (pending != '0) state_d = StReq;
      StReq: begin
        if (ref_gnt_i) begin
          state_d = StPre;
          timer_d = TimerW'(T_RP - 1);
        end
      end
      StPre: begin
        if (timer_q == '0) begin
          state_d = StRef;
          timer_d = TimerW'(T_RFC - 1);
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StRef: begin
        if (timer_q == '0) state_d = StDone;
        else               timer_d = timer_q - TimerW'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ref_req_o     = 1'b0;
    ref_active_o  = 1'b0;
    cmd_pre_all_o = 1'b0;
    cmd_ref_o     = 1'b0;
    ref_done_o    = 1'b0;
    unique case (state_q)
      StReq: ref_req_o = 1'b1;
      StPre: begin
        ref_req_o     = 1'b1;
        ref_active_o  = 1'b1;
        cmd_pre_all_o = (timer_q == TimerW'(T_RP - 1));
      end
      StRef: begin
        ref_req_o    = 1'b1;
        ref_active_o = 1'b1;
        cmd_ref_o    = (timer_q == TimerW'(T_RFC - 1));
      end
      StDone:  ref_done_o = 1'b1;
      default: ;
    endcase
  end

  assign ref_urgent_o = (pending >= PendW'(URGENT_LEVEL));
  assign pending_o    = pending;

endmodule

// File: tb/tb_refresh_executor.sv
// Randomized bench for refresh_executor against a cycle-offset reference model
// that derives every output from the grant cycle and the backlog rules.
module tb_refresh_executor;
  import refresh_pkg::*;

  localparam int unsigned MaxP  = 8;
  localparam int unsigned Urg   = 6;
  localparam int unsigned TRp   = 3;
  localparam int unsigned TRfc  = 16;
  localparam int unsigned PendW = pending_width(MaxP);
  localparam int          NumCycles = 8000;

  logic             clk = 1'b0;
  logic             rst, refresh, ref_gnt;
  logic             ref_req, ref_urgent, cmd_pre_all, cmd_ref, ref_active, ref_done;
  logic [PendW-1:0] pending;
  logic             overflow;

  always #5 clk = ~clk;

  refresh_executor #(
    .MAX_PENDING (MaxP),
    .URGENT_LEVEL(Urg),
    .T_RP        (TRp),
    .T_RFC       (TRfc)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .refresh_i    (refresh),
    .ref_gnt_i    (ref_gnt),
    .ref_req_o    (ref_req),
    .ref_urgent_o (ref_urgent),
    .cmd_pre_all_o(cmd_pre_all),
    .cmd_ref_o    (cmd_ref),
    .ref_active_o (ref_active),
    .ref_done_o   (ref_done),
    .pending_o    (pending),
    .overflow_o   (overflow)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Model: backlog as an integer; a sequence is described only by whether the
  // bus is being requested and the cycle the grant was taken.
  int m_pend, m_ovf, m_req, m_k;
  int off, e_req, e_act, e_pre, e_ref, e_done, old_pend;
  int seg_left, gnt_pct, ref_pct;
  int n_ovf_seen, n_ref_seen;

  initial begin
    rst = 1'b1; refresh = 1'b0; ref_gnt = 1'b0;
    m_pend = 0; m_ovf = 0; m_req = 0; m_k = -1;
    seg_left = 0; gnt_pct = 100; ref_pct = 0;
    n_ovf_seen = 0; n_ref_seen = 0;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < NumCycles; c++) begin
      cyc = c;
      off    = (m_k >= 0) ? (c - m_k) : -1;
      e_pre  = (off >= 1 && off <= int'(TRp)) ? 1 : 0;
      e_ref  = (off >= int'(TRp) + 1 && off <= int'(TRp + TRfc)) ? 1 : 0;
      e_done = (off == int'(TRp + TRfc) + 1) ? 1 : 0;
      e_act  = e_pre | e_ref;
      e_req  = ((m_req != 0) && (m_k < 0)) ? 1 : e_act;

      check_eq("ref_req",     int'(ref_req),     e_req);
      check_eq("ref_active",  int'(ref_active),  e_act);
      check_eq("cmd_pre_all", int'(cmd_pre_all), (off == 1) ? 1 : 0);
      check_eq("cmd_ref",     int'(cmd_ref),     (off == int'(TRp) + 1) ? 1 : 0);
      check_eq("ref_done",    int'(ref_done),    e_done);
      check_eq("pending",     int'(pending),     m_pend);
      check_eq("ref_urgent",  int'(ref_urgent),  (m_pend >= int'(Urg)) ? 1 : 0);
      check_eq("overflow",    int'(overflow),    m_ovf);
      if (m_ovf != 0) n_ovf_seen++;
      if (off == int'(TRp) + 1) n_ref_seen++;

      // Stimulus: a directed single request first, then random segments.
      if (c < 60) begin
        rst     = (c < 1) ? 1'b1 : 1'b0;
        ref_gnt = 1'b1;
        refresh = (c == 10) ? 1'b1 : 1'b0;
      end else begin
        if (seg_left == 0) begin
          seg_left = $urandom_range(20, 250);
          case ($urandom_range(0, 3))
            0: gnt_pct = 0;
            1: gnt_pct = 20;
            2: gnt_pct = 70;
            default: gnt_pct = 100;
          endcase
          case ($urandom_range(0, 2))
            0: ref_pct = 2;
            1: ref_pct = 10;
            default: ref_pct = 40;
          endcase
        end
        seg_left--;
        rst     = ($urandom_range(0, 999) < 3) ? 1'b1 : 1'b0;
        ref_gnt = ($urandom_range(0, 99) < gnt_pct) ? 1'b1 : 1'b0;
        refresh = ($urandom_range(0, 99) < ref_pct) ? 1'b1 : 1'b0;
      end

      if (rst) begin
        m_pend = 0; m_ovf = 0; m_req = 0; m_k = -1;
      end else begin
        old_pend = m_pend;
        if (refresh && !(off == int'(TRp) + 1)) begin
          if (m_pend == int'(MaxP)) m_ovf = 1;
          else                      m_pend++;
        end else if (!refresh && (off == int'(TRp) + 1) && m_pend > 0) begin
          m_pend--;
        end
        if (m_req == 0 && m_k < 0) begin
          if (old_pend != 0) m_req = 1;
        end else if (m_k < 0) begin
          if (ref_gnt) m_k = c;
        end else if (e_done != 0) begin
          m_k = -1; m_req = 0;
        end
      end
      @(negedge clk);
    end
    check_eq("saw_overflow", (n_ovf_seen > 0) ? 1 : 0, 1);
    check_eq("saw_refresh",  (n_ref_seen > 10) ? 1 : 0, 1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
